// File: rtl/sdram_axi_arb.sv
// 2:1 transaction-level AXI4 arbiter in front of the SDRAM slave port; one burst in flight at a time.
// Optional per-master completion counters are built when SDRAM_ARB_STAT_EN is defined.
module sdram_axi_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // master s0
  input  logic                s0_awvalid,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  output logic                s0_awready,
  input  logic                s0_wvalid,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  output logic                s0_wready,
  output logic                s0_bvalid,
  output logic [1:0]          s0_bresp,
  output logic [ID_W-1:0]     s0_bid,
  input  logic                s0_bready,
  input  logic                s0_arvalid,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [ID_W-1:0]     s0_arid,
  input  logic [7:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  output logic                s0_arready,
  output logic                s0_rvalid,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  output logic [ID_W-1:0]     s0_rid,
  input  logic                s0_rready,
  // master s1
  input  logic                s1_awvalid,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  output logic                s1_awready,
  input  logic                s1_wvalid,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  output logic                s1_wready,
  output logic                s1_bvalid,
  output logic [1:0]          s1_bresp,
  output logic [ID_W-1:0]     s1_bid,
  input  logic                s1_bready,
  input  logic                s1_arvalid,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [ID_W-1:0]     s1_arid,
  input  logic [7:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  output logic                s1_arready,
  output logic                s1_rvalid,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic [ID_W-1:0]     s1_rid,
  input  logic                s1_rready,
  // downstream slave
  output logic                out_awvalid,
  output logic [ADDR_W-1:0]   out_awaddr,
  output logic [ID_W-1:0]     out_awid,
  output logic [7:0]          out_awlen,
  output logic [2:0]          out_awsize,
  output logic [1:0]          out_awburst,
  output logic                out_awlock,
  output logic [3:0]          out_awcache,
  output logic [2:0]          out_awprot,
  input  logic                out_awready,
  output logic                out_wvalid,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_wlast,
  input  logic                out_wready,
  input  logic                out_bvalid,
  input  logic [1:0]          out_bresp,
  input  logic [ID_W-1:0]     out_bid,
  output logic                out_bready,
  output logic                out_arvalid,
  output logic [ADDR_W-1:0]   out_araddr,
  output logic [ID_W-1:0]     out_arid,
  output logic [7:0]          out_arlen,
  output logic [2:0]          out_arsize,
  output logic [1:0]          out_arburst,
  output logic                out_arlock,
  output logic [3:0]          out_arcache,
  output logic [2:0]          out_arprot,
  input  logic                out_arready,
  input  logic                out_rvalid,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  input  logic                out_rlast,
  input  logic [ID_W-1:0]     out_rid,
  output logic                out_rready,
  output logic [STAT_W-1:0]   stat_s0_cnt,
  output logic [STAT_W-1:0]   stat_s1_cnt
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

  state_e state_q, state_d;
  logic   g_q, g_d;
  logic   last_g_q, last_g_d;
  logic   done;
  logic   st_ar, st_r, st_aw, st_w, st_b;

  assign st_ar = (state_q == StAr);
  assign st_r  = (state_q == StR);
  assign st_aw = (state_q == StAw);
  assign st_w  = (state_q == StW);
  assign st_b  = (state_q == StB);

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_g_d = last_g_q;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((s0_awvalid | s0_arvalid) | (s1_awvalid | s1_arvalid)) begin
          if ((s0_awvalid | s0_arvalid) & (s1_awvalid | s1_arvalid)) g_d = ~last_g_q;
          else                                                        g_d = s1_awvalid | s1_arvalid;
          // Write wins over read within the newly granted master.
          state_d = (g_d ? s1_awvalid : s0_awvalid) ? StAw : StAr;
        end
      end
      StAr: if (out_arvalid & out_arready) state_d = StR;
      StR: begin
        if (out_rvalid & out_rready & out_rlast) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      StAw: if (out_awvalid & out_awready) state_d = StW;
      StW:  if (out_wvalid & out_wready & out_wlast) state_d = StB;
      StB: begin
        if (out_bvalid & out_bready) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (done) last_g_d = g_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      g_q      <= 1'b0;
      last_g_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_g_q <= last_g_d;
    end
  end

  // Request channels: data always follows the registered grant, valid gated by state.
  assign out_awvalid = st_aw & (g_q ? s1_awvalid : s0_awvalid);
  assign out_awaddr  = g_q ? s1_awaddr  : s0_awaddr;
  assign out_awid    = g_q ? s1_awid    : s0_awid;
  assign out_awlen   = g_q ? s1_awlen   : s0_awlen;
  assign out_awsize  = g_q ? s1_awsize  : s0_awsize;
  assign out_awburst = g_q ? s1_awburst : s0_awburst;
  assign out_awlock  = 1'b0;
  assign out_awcache = 4'd0;
  assign out_awprot  = 3'd0;

  assign out_wvalid  = st_w & (g_q ? s1_wvalid : s0_wvalid);
  assign out_wdata   = g_q ? s1_wdata : s0_wdata;
  assign out_wstrb   = g_q ? s1_wstrb : s0_wstrb;
  assign out_wlast   = g_q ? s1_wlast : s0_wlast;
  assign out_bready  = st_b & (g_q ? s1_bready : s0_bready);

  assign out_arvalid = st_ar & (g_q ? s1_arvalid : s0_arvalid);
  assign out_araddr  = g_q ? s1_araddr  : s0_araddr;
  assign out_arid    = g_q ? s1_arid    : s0_arid;
  assign out_arlen   = g_q ? s1_arlen   : s0_arlen;
  assign out_arsize  = g_q ? s1_arsize  : s0_arsize;
  assign out_arburst = g_q ? s1_arburst : s0_arburst;
  assign out_arlock  = 1'b0;
  assign out_arcache = 4'd0;
  assign out_arprot  = 3'd0;
  assign out_rready  = st_r & (g_q ? s1_rready : s0_rready);

  assign s0_awready = st_aw & ~g_q & out_awready;
  assign s1_awready = st_aw &  g_q & out_awready;
  assign s0_wready  = st_w  & ~g_q & out_wready;
  assign s1_wready  = st_w  &  g_q & out_wready;
  assign s0_arready = st_ar & ~g_q & out_arready;
  assign s1_arready = st_ar &  g_q & out_arready;

  assign s0_bvalid = st_b & ~g_q & out_bvalid;
  assign s1_bvalid = st_b &  g_q & out_bvalid;
  assign s0_bresp  = out_bresp;
  assign s1_bresp  = out_bresp;
  assign s0_bid    = out_bid;
  assign s1_bid    = out_bid;

  assign s0_rvalid = st_r & ~g_q & out_rvalid;
  assign s1_rvalid = st_r &  g_q & out_rvalid;
  assign s0_rdata  = out_rdata;
  assign s1_rdata  = out_rdata;
  assign s0_rresp  = out_rresp;
  assign s1_rresp  = out_rresp;
  assign s0_rlast  = out_rlast;
  assign s1_rlast  = out_rlast;
  assign s0_rid    = out_rid;
  assign s1_rid    = out_rid;

`ifdef SDRAM_ARB_STAT_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done) begin
      if (g_q) cnt1_q <= cnt1_q + STAT_W'(1);
      else     cnt0_q <= cnt0_q + STAT_W'(1);
    end
  end

  assign stat_s0_cnt = cnt0_q;
  assign stat_s1_cnt = cnt1_q;
`else
  assign stat_s0_cnt = '0;
  assign stat_s1_cnt = '0;
`endif

endmodule

// File: tb/tb_sdram_axi_arb.sv
// Bench for sdram_axi_arb: two bench-driven masters, a small SDRAM slave model, and a read scoreboard.
module tb_sdram_axi_arb;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        aw_valid[2], aw_ready[2];
  logic [31:0] aw_addr[2];
  logic [3:0]  aw_id[2];
  logic [7:0]  aw_len[2];
  logic [2:0]  aw_size[2];
  logic [1:0]  aw_burst[2];
  logic        w_valid[2], w_last[2], w_ready[2];
  logic [31:0] w_data[2];
  logic [3:0]  w_strb[2];
  logic        b_valid[2], b_ready[2];
  logic [1:0]  b_resp[2];
  logic [3:0]  b_id[2];
  logic        ar_valid[2], ar_ready[2];
  logic [31:0] ar_addr[2];
  logic [3:0]  ar_id[2];
  logic [7:0]  ar_len[2];
  logic [2:0]  ar_size[2];
  logic [1:0]  ar_burst[2];
  logic        r_valid[2], r_last[2], r_ready[2];
  logic [31:0] r_data[2];
  logic [1:0]  r_resp[2];
  logic [3:0]  r_id[2];

  logic        out_awvalid, out_awready, out_awlock, out_wvalid, out_wready, out_wlast;
  logic [31:0] out_awaddr, out_wdata, out_araddr, out_rdata;
  logic [3:0]  out_awid, out_awcache, out_wstrb, out_bid, out_arid, out_arcache, out_rid;
  logic [7:0]  out_awlen, out_arlen;
  logic [2:0]  out_awsize, out_awprot, out_arsize, out_arprot;
  logic [1:0]  out_awburst, out_arburst, out_bresp, out_rresp;
  logic        out_bvalid, out_bready, out_arvalid, out_arready, out_arlock;
  logic        out_rvalid, out_rready, out_rlast;
  logic [31:0] stat_s0_cnt, stat_s1_cnt;

  sdram_axi_arb dut (
    .clock(clock), .reset(reset),
    .s0_awvalid(aw_valid[0]), .s0_awaddr(aw_addr[0]), .s0_awid(aw_id[0]), .s0_awlen(aw_len[0]),
    .s0_awsize(aw_size[0]), .s0_awburst(aw_burst[0]), .s0_awready(aw_ready[0]),
    .s0_wvalid(w_valid[0]), .s0_wdata(w_data[0]), .s0_wstrb(w_strb[0]), .s0_wlast(w_last[0]),
    .s0_wready(w_ready[0]), .s0_bvalid(b_valid[0]), .s0_bresp(b_resp[0]), .s0_bid(b_id[0]),
    .s0_bready(b_ready[0]), .s0_arvalid(ar_valid[0]), .s0_araddr(ar_addr[0]), .s0_arid(ar_id[0]),
    .s0_arlen(ar_len[0]), .s0_arsize(ar_size[0]), .s0_arburst(ar_burst[0]),
    .s0_arready(ar_ready[0]), .s0_rvalid(r_valid[0]), .s0_rdata(r_data[0]), .s0_rresp(r_resp[0]),
    .s0_rlast(r_last[0]), .s0_rid(r_id[0]), .s0_rready(r_ready[0]),
    .s1_awvalid(aw_valid[1]), .s1_awaddr(aw_addr[1]), .s1_awid(aw_id[1]), .s1_awlen(aw_len[1]),
    .s1_awsize(aw_size[1]), .s1_awburst(aw_burst[1]), .s1_awready(aw_ready[1]),
    .s1_wvalid(w_valid[1]), .s1_wdata(w_data[1]), .s1_wstrb(w_strb[1]), .s1_wlast(w_last[1]),
    .s1_wready(w_ready[1]), .s1_bvalid(b_valid[1]), .s1_bresp(b_resp[1]), .s1_bid(b_id[1]),
    .s1_bready(b_ready[1]), .s1_arvalid(ar_valid[1]), .s1_araddr(ar_addr[1]), .s1_arid(ar_id[1]),
    .s1_arlen(ar_len[1]), .s1_arsize(ar_size[1]), .s1_arburst(ar_burst[1]),
    .s1_arready(ar_ready[1]), .s1_rvalid(r_valid[1]), .s1_rdata(r_data[1]), .s1_rresp(r_resp[1]),
    .s1_rlast(r_last[1]), .s1_rid(r_id[1]), .s1_rready(r_ready[1]),
    .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_awlock(out_awlock), .out_awcache(out_awcache), .out_awprot(out_awprot),
    .out_awready(out_awready), .out_wvalid(out_wvalid), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wready(out_wready),
    .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bid(out_bid), .out_bready(out_bready),
    .out_arvalid(out_arvalid), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_arlock(out_arlock), .out_arcache(out_arcache), .out_arprot(out_arprot),
    .out_arready(out_arready), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid), .out_rready(out_rready),
    .stat_s0_cnt(stat_s0_cnt), .stat_s1_cnt(stat_s1_cnt)
  );

  // Downstream slave model: 256-word memory, one read and one write context, shares reset.
  logic [31:0] smem[256];
  logic [31:0] ref_mem[256];
  logic        s_rd_busy, s_wr_act, s_b_pend;
  logic [7:0]  s_rd_idx, s_rd_cnt, s_rd_len, s_wr_idx;
  logic [3:0]  s_rd_id, s_wr_id;

  initial for (int i = 0; i < 256; i++) begin
    smem[i]    = 32'hA500_0000 | i;
    ref_mem[i] = 32'hA500_0000 | i;
  end

  assign out_arready = !s_rd_busy;
  assign out_awready = !s_wr_act && !s_b_pend;
  assign out_wready  = s_wr_act;
  assign out_rvalid  = s_rd_busy;
  assign out_rdata   = smem[8'(s_rd_idx + s_rd_cnt)];
  assign out_rlast   = (s_rd_cnt == s_rd_len);
  assign out_rid     = s_rd_id;
  assign out_rresp   = 2'd0;
  assign out_bvalid  = s_b_pend;
  assign out_bresp   = 2'd0;
  assign out_bid     = s_wr_id;

  always @(posedge clock) begin
    if (reset) begin
      s_rd_busy <= 1'b0; s_wr_act <= 1'b0; s_b_pend <= 1'b0;
      s_rd_idx <= 8'd0; s_rd_cnt <= 8'd0; s_rd_len <= 8'd0; s_wr_idx <= 8'd0;
      s_rd_id <= 4'd0; s_wr_id <= 4'd0;
    end else begin
      if (out_arvalid && out_arready) begin
        s_rd_busy <= 1'b1; s_rd_idx <= out_araddr[9:2]; s_rd_cnt <= 8'd0;
        s_rd_len <= out_arlen; s_rd_id <= out_arid;
      end else if (out_rvalid && out_rready) begin
        if (out_rlast) s_rd_busy <= 1'b0;
        else           s_rd_cnt <= s_rd_cnt + 8'd1;
      end
      if (out_awvalid && out_awready) begin
        s_wr_act <= 1'b1; s_wr_idx <= out_awaddr[9:2]; s_wr_id <= out_awid;
      end else if (out_wvalid && out_wready) begin
        for (int k = 0; k < 4; k++)
          if (out_wstrb[k]) smem[s_wr_idx][8*k +: 8] <= out_wdata[8*k +: 8];
        s_wr_idx <= s_wr_idx + 8'd1;
        if (out_wlast) begin s_wr_act <= 1'b0; s_b_pend <= 1'b1; end
      end
      if (out_bvalid && out_bready) s_b_pend <= 1'b0;
    end
  end

  typedef struct {logic [31:0] data; logic [3:0] id; logic last;} beat_t;
  beat_t rq[2][$];
  int    order_q[$];   // completions: master + 2*is_write
  int    checks = 0, errors = 0;
  bit    rd_out[2], wr_out[2];
  bit    model_last;
  int    cnt_model[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int m, input int k);
    case (k)
      0:       return ar_ready[m];
      1:       return aw_ready[m];
      2:       return w_ready[m];
      3:       return r_valid[m];
      default: return b_valid[m];
    endcase
  endfunction

  // Returns at the negedge where the signal is high; n = number of low negedges before it.
  task automatic wait_sig(input int m, input int k, input string nm, output int n);
    n = 0;
    forever begin
      @(negedge clock);
      if (sig(m, k)) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL timeout %s m%0d t=%0t", nm, m, $time);
        break;
      end
    end
  endtask

  function automatic logic any_hs();
    return out_arvalid | out_awvalid | out_wvalid | out_rready | out_bready |
           ar_ready[0] | ar_ready[1] | aw_ready[0] | aw_ready[1] | w_ready[0] | w_ready[1] |
           r_valid[0] | r_valid[1] | b_valid[0] | b_valid[1];
  endfunction

  task automatic complete(input int m, input int wr);
    order_q.push_back(m + 2 * wr);
    model_last = (m != 0);
    cnt_model[m]++;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, output int lat, output logic [31:0] first);
    int n;
    logic [7:0] idx;
    beat_t e;
    idx = addr[9:2];
    first = 32'hX;
    rd_out[m] = 1'b1;
    for (int b = 0; b <= int'(len); b++) rq[m].push_back('{ref_mem[8'(idx + b)], id, b == int'(len)});
    ar_addr[m] = addr; ar_id[m] = id; ar_len[m] = len; ar_size[m] = 3'd2; ar_burst[m] = 2'd1;
    ar_valid[m] = 1'b1;
    wait_sig(m, 0, "arready", lat);
    chk("out_araddr", out_araddr, addr);
    chk("out_arid", 32'(out_arid), 32'(id));
    chk("out_arlen", 32'(out_arlen), 32'(len));
    @(posedge clock); #1;
    ar_valid[m] = 1'b0;
    r_ready[m] = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      wait_sig(m, 3, "rvalid", n);
      if (n > 300) break;
      if (b == 0) first = r_data[m];
      if (rq[m].size() == 0) begin
        chk("r_extra_beat", 32'(rq[m].size()), 32'd1);
      end else begin
        e = rq[m].pop_front();
        chk("rdata", r_data[m], e.data);
        chk("rid", 32'(r_id[m]), 32'(e.id));
        chk("rlast", 32'(r_last[m]), 32'(e.last));
      end
      @(posedge clock); #1;
    end
    r_ready[m] = 1'b0;
    rd_out[m] = 1'b0;
    complete(m, 0);
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] data, input logic [3:0] strb, input logic [3:0] id,
                          input bit early, output int lat, output logic [31:0] resp);
    int n;
    logic [7:0] idx;
    logic [31:0] d;
    idx = addr[9:2];
    wr_out[m] = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      d = data + 32'(b);
      for (int k = 0; k < 4; k++) if (strb[k]) ref_mem[8'(idx + b)][8*k +: 8] = d[8*k +: 8];
    end
    w_data[m] = data; w_strb[m] = strb; w_last[m] = (len == 8'd0);
    if (early) begin
      w_valid[m] = 1'b1;
      repeat (3) begin
        @(negedge clock);
        chk("early_wready", 32'(w_ready[m]), 32'd0);
      end
      @(posedge clock); #1;
    end
    aw_addr[m] = addr; aw_id[m] = id; aw_len[m] = len; aw_size[m] = 3'd2; aw_burst[m] = 2'd1;
    aw_valid[m] = 1'b1;
    wait_sig(m, 1, "awready", lat);
    if (early) chk("wready_before_aw_hs", 32'(w_ready[m]), 32'd0);
    chk("out_awaddr", out_awaddr, addr);
    chk("out_awid", 32'(out_awid), 32'(id));
    @(posedge clock); #1;
    aw_valid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = data + 32'(b);
      w_data[m] = d; w_last[m] = (b == int'(len)); w_valid[m] = 1'b1;
      wait_sig(m, 2, "wready", n);
      chk("out_wdata", out_wdata, d);
      chk("out_wstrb", 32'(out_wstrb), 32'(strb));
      @(posedge clock); #1;
    end
    w_valid[m] = 1'b0; w_last[m] = 1'b0;
    b_ready[m] = 1'b1;
    wait_sig(m, 4, "bvalid", n);
    resp = 32'(b_resp[m]);
    chk("bid", 32'(b_id[m]), 32'(id));
    @(posedge clock); #1;
    b_ready[m] = 1'b0;
    wr_out[m] = 1'b0;
    complete(m, 1);
  endtask

  // Responses may only reach a master that has a matching transaction outstanding.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      for (int m = 0; m < 2; m++) begin
        if (r_valid[m]) chk("stray_rvalid", 32'(rd_out[m]), 32'd1);
        if (b_valid[m]) chk("stray_bvalid", 32'(wr_out[m]), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  typedef struct {
    bit m; bit wr; logic [31:0] addr; logic [7:0] len; logic [31:0] data;
    logic [3:0] strb; logic [3:0] id; logic [31:0] exp0;
  } vec_t;
  vec_t vt[6];

  int          lat, n0, n1, exp_first, sz, exp_s0, exp_s1;
  logic [31:0] first, d0, d1;

  initial begin
    // exp0: first read beat for reads, bresp for writes
    vt[0] = '{0, 0, 32'hA000_0000, 8'd3, 32'h0,         4'h0, 4'd1, 32'hA500_0000};
    vt[1] = '{1, 1, 32'h0000_0010, 8'd0, 32'hDEAD_BEEF, 4'hF, 4'd2, 32'h0};
    vt[2] = '{1, 0, 32'h0000_0010, 8'd0, 32'h0,         4'h0, 4'd3, 32'hDEAD_BEEF};
    vt[3] = '{0, 1, 32'h0000_0020, 8'd1, 32'h1122_3344, 4'h3, 4'd5, 32'h0};
    vt[4] = '{0, 0, 32'h0000_0020, 8'd1, 32'h0,         4'h0, 4'd6, 32'hA500_3344};
    vt[5] = '{1, 0, 32'h0000_0040, 8'd7, 32'h0,         4'h0, 4'd7, 32'hA500_0010};

    for (int m = 0; m < 2; m++) begin
      aw_valid[m] = 0; aw_addr[m] = 0; aw_id[m] = 0; aw_len[m] = 0; aw_size[m] = 0;
      aw_burst[m] = 0; w_valid[m] = 0; w_data[m] = 0; w_strb[m] = 0; w_last[m] = 0;
      b_ready[m] = 0; ar_valid[m] = 0; ar_addr[m] = 0; ar_id[m] = 0; ar_len[m] = 0;
      ar_size[m] = 0; ar_burst[m] = 0; r_ready[m] = 0; rd_out[m] = 0; wr_out[m] = 0;
      cnt_model[m] = 0;
    end
    model_last = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_idle", 32'(any_hs()), 32'd0);
    chk("reset_stat0", stat_s0_cnt, 32'd0);
    chk("reset_stat1", stat_s1_cnt, 32'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("idle_no_req", 32'(any_hs()), 32'd0);
    end
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      if (vt[i].wr)
        do_write(int'(vt[i].m), vt[i].addr, vt[i].len, vt[i].data, vt[i].strb, vt[i].id, 1'b0,
                 lat, first);
      else
        do_read(int'(vt[i].m), vt[i].addr, vt[i].len, vt[i].id, lat, first);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_first", i), first, vt[i].exp0);
    end

    // s1 requests write and read together: write first, then read.
    fork
      do_write(1, 32'h80, 8'd0, 32'hDEAD_BEEF, 4'hF, 4'd9, 1'b0, n0, d0);
      do_read(1, 32'hC0, 8'd0, 4'd10, n1, d1);
    join
    sz = order_q.size();
    chk("wprio_first_is_write", 32'(order_q[sz-2]), 32'd3);
    chk("wprio_then_read", 32'(order_q[sz-1]), 32'd1);
    chk("wprio_bresp", d0, 32'd0);
    chk("wprio_read_data", d1, 32'hA500_0030);
    do_read(1, 32'h80, 8'd0, 4'd11, lat, first);
    chk("readback", first, 32'hDEAD_BEEF);

    // Early W beats from s0.
    do_write(0, 32'h200, 8'd1, 32'hCAFE_F00D, 4'hF, 4'd3, 1'b1, lat, first);
    do_read(0, 32'h200, 8'd1, 4'd4, lat, first);
    chk("early_w_readback", first, 32'hCAFE_F00D);

    // Reset during the second beat of an 8-beat read.
    rd_out[1] = 1'b1;
    ar_addr[1] = 32'h100; ar_id[1] = 4'd4; ar_len[1] = 8'd7; ar_size[1] = 3'd2;
    ar_burst[1] = 2'd1; ar_valid[1] = 1'b1;
    wait_sig(1, 0, "arready_mb", n0);
    @(posedge clock); #1;
    ar_valid[1] = 1'b0;
    r_ready[1] = 1'b1;
    wait_sig(1, 3, "rvalid_mb1", n0);
    @(posedge clock); #1;
    wait_sig(1, 3, "rvalid_mb2", n0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midburst_idle", 32'(any_hs()), 32'd0);
    chk("midburst_stat0", stat_s0_cnt, 32'd0);
    chk("midburst_stat1", stat_s1_cnt, 32'd0);
    r_ready[1] = 1'b0;
    rd_out[1] = 1'b0;
    model_last = 1'b1;
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_idle", 32'(any_hs()), 32'd0);
    @(posedge clock); #1;

    // Completion counters: 3 s0 reads, 2 s1 writes.
    for (int i = 0; i < 3; i++) do_read(0, 32'h300 + 32'(4 * i), 8'd0, 4'd1, lat, first);
    for (int i = 0; i < 2; i++)
      do_write(1, 32'h380 + 32'(4 * i), 8'd0, 32'h5500_0000 + 32'(i), 4'hF, 4'd2, 1'b0, lat, first);
`ifdef SDRAM_ARB_STAT_EN
    exp_s0 = 3; exp_s1 = 2;
`else
    exp_s0 = 0; exp_s1 = 0;
`endif
    chk("stat_s0", stat_s0_cnt, 32'(exp_s0));
    chk("stat_s1", stat_s1_cnt, 32'(exp_s1));

    // Four read ties: winner is the master that did not complete last.
    for (int t = 0; t < 4; t++) begin
      exp_first = model_last ? 0 : 1;
      fork
        do_read(0, 32'h3C0, 8'd1, 4'd12, n0, d0);
        do_read(1, 32'h3E0, 8'd1, 4'd13, n1, d1);
      join
      sz = order_q.size();
      chk($sformatf("tie%0d_winner", t), 32'(order_q[sz-2]), 32'(exp_first));
      chk($sformatf("tie%0d_second", t), 32'(order_q[sz-1]), 32'(1 - exp_first));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
